// File: rtl/kamus_pkg.sv
// Shared types for the kamus core: decoded operation codes, ID-stage FSM
// states and the canonical NOP encoding.
package kamus_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_LW,
    OP_SW,
    OP_BRANCH,
    OP_JAL,
    OP_FENCE,
    OP_FENCE_I,
    OP_CSR,
    OP_ECALL,
    OP_EBREAK,
    OP_INVALID
  } operation_e;

  typedef logic [2:0] id_state_e;

  localparam id_state_e RUN       = 3'd0;
  localparam id_state_e HAZ       = 3'd1;
  localparam id_state_e DRAIN     = 3'd2;
  localparam id_state_e ISSUE_SER = 3'd3;
  localparam id_state_e POST      = 3'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Operations that must run alone: everything older retired, nothing younger in flight.
  function automatic logic is_serialising(operation_e op);
    return op inside {OP_FENCE, OP_FENCE_I, OP_CSR, OP_ECALL, OP_EBREAK};
  endfunction

endpackage

// File: rtl/kamus_scoreboard.sv
// Per-register outstanding-write counters; x0 is never tracked and always reads idle.
module kamus_scoreboard
  import kamus_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int PEND_W   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic [AW-1:0] set_rd_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_rd_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic [AW-1:0] rd_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o,
  output logic          rd_sat_o,
  output logic          all_zero_o
);

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];

  // A simultaneous set and clear of one register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (set_i && set_rd_i == AW'(r) && !(clr_i && clr_rd_i == AW'(r))) begin
        if (cnt_q[r] != '1) cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (clr_i && clr_rd_i == AW'(r) && !(set_i && set_rd_i == AW'(r))) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '{default: '0};
    else       cnt_q <= cnt_d;
  end

  assign rs1_busy_o = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
  assign rs2_busy_o = (rs2_i != '0) && (cnt_q[rs2_i] != '0);
  assign rd_sat_o   = (rd_i  != '0) && (cnt_q[rd_i]  == '1);

  always_comb begin
    all_zero_o = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) all_zero_o = 1'b0;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    (clr_i && clr_rd_i != '0 && !(set_i && set_rd_i == clr_rd_i)) |-> (cnt_q[clr_rd_i] != '0));

endmodule

// File: rtl/kamus_id_issue_ctrl.sv
// ID-stage issue controller: holds one IF instruction, checks RAW/serialising
// hazards against the write scoreboard and hands instructions to EX.
module kamus_id_issue_ctrl
  import kamus_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [31:0]         if_instr_i,
  input  logic [PC_WIDTH-1:0] if_pc_i,
  output logic [31:0]         dec_instr_o,
  input  operation_e          dec_op_i,
  input  logic [4:0]          dec_rs1_i,
  input  logic [4:0]          dec_rs2_i,
  input  logic [4:0]          dec_rd_i,
  input  logic                dec_uses_rs1_i,
  input  logic                dec_uses_rs2_i,
  input  logic                dec_writes_rd_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [PC_WIDTH-1:0] ex_pc_o,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  input  logic                flush_i,
  input  logic                ex_idle_i,
  output logic                stall_o
);

  logic                id_valid_q, id_valid_d;
  logic [31:0]         id_instr_q, id_instr_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  id_state_e           state_q, state_d;

  logic rs1_busy, rs2_busy, rd_sat, all_zero;
  logic hz, ser, issue_ok, fire, accept;

  kamus_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (fire && dec_writes_rd_i),
    .set_rd_i   (dec_rd_i),
    .clr_i      (wb_valid_i),
    .clr_rd_i   (wb_rd_i),
    .rs1_i      (dec_rs1_i),
    .rs2_i      (dec_rs2_i),
    .rd_i       (dec_rd_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_sat_o   (rd_sat),
    .all_zero_o (all_zero)
  );

  // A saturated destination counter is treated like a RAW hazard.
  assign hz  = (dec_uses_rs1_i && rs1_busy) || (dec_uses_rs2_i && rs2_busy) ||
               (dec_writes_rd_i && rd_sat);
  assign ser = is_serialising(dec_op_i);

  always_comb begin
    issue_ok = 1'b0;
    case (state_q)
      RUN, HAZ:  issue_ok = !hz && !ser;
      ISSUE_SER: issue_ok = 1'b1;
      default:   issue_ok = 1'b0;
    endcase
  end

  assign ex_valid_o  = id_valid_q && issue_ok && !flush_i;
  assign fire        = ex_valid_o && ex_ready_i;
  assign stall_o     = id_valid_q && !issue_ok;
  assign if_ready_o  = !id_valid_q || fire;
  assign accept      = if_valid_i && if_ready_o && !flush_i;
  assign ex_pc_o     = id_pc_q;
  assign dec_instr_o = id_valid_q ? id_instr_q : NOP_INSTR;

  // Flush empties ID and restarts the FSM but leaves the scoreboard alone.
  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    state_d    = state_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
      state_d    = RUN;
    end else begin
      if (accept) begin
        id_valid_d = 1'b1;
        id_instr_d = if_instr_i;
        id_pc_d    = if_pc_i;
      end else if (fire) begin
        id_valid_d = 1'b0;
      end
      case (state_q)
        RUN:       if (id_valid_q) begin
                     if (ser)     state_d = DRAIN;
                     else if (hz) state_d = HAZ;
                   end
        HAZ:       if (!hz) state_d = RUN;
        DRAIN:     if (all_zero && ex_idle_i) state_d = ISSUE_SER;
        ISSUE_SER: if (fire) state_d = POST;
        POST:      if (ex_idle_i) state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      state_q    <= RUN;
    end else begin
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: doc/kamus_id_issue_ctrl.md
Name: kamus_id_issue_ctrl

Overview:
Issue controller that sequences the instruction-decode stage. It registers IF->ID instructions under a valid/ready handshake and tracks outstanding register writes in a per-register scoreboard. It holds back instructions with RAW hazards or serialising operations (FENCE, FENCE_I, CSR, ECALL/EBREAK), and launches decoded instructions into EX. It sits between kamus_IF, the decoder and the EX stage, and owns the ID stall/flush policy.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never tracked.
PEND_W, 2, width of each per-register outstanding-write counter (max 2^PEND_W-1 in flight).
PC_WIDTH, 32, program counter width.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
if_valid_i  in  1  IF presents instr/pc
if_ready_o  out  1  ID can accept from IF
if_instr_i  in  32  fetched instruction
if_pc_i  in  PC_WIDTH  fetched pc
dec_instr_o  out  32  held instruction to decoder
dec_op_i  in  operation_e  decoded operation
dec_rs1_i / dec_rs2_i / dec_rd_i  in  5 each  decoded register addresses
dec_uses_rs1_i / dec_uses_rs2_i / dec_writes_rd_i  in  1 each  operand/dest usage
ex_valid_o  out  1  issue to EX this cycle
ex_ready_i  in  1  EX accepts
ex_pc_o  out  PC_WIDTH  pc of issued instruction
wb_valid_i  in  1  a register write retires
wb_rd_i  in  5  retired destination
flush_i  in  1  redirect from EX (branch/trap); kills ID contents
ex_idle_i  in  1  EX/MEM/WB contain no live instruction
stall_o  out  1  ID holding a valid instruction that cannot issue

Behaviour:
- Reset: if_ready_o=1, ex_valid_o=0, stall_o=0, ex_pc_o=0, dec_instr_o=32'h0000_0013 (NOP), ID register empty, all counters 0, FSM=RUN.
- ID register: loads on if_valid_i && if_ready_o. if_ready_o = !id_valid || (issue fire). Latency IF accept -> ex_valid_o is 1 cycle minimum.
- Hazard: hz = (uses_rs1 && rs1!=0 && cnt[rs1]!=0) || (same for rs2). WB to the same register in the same cycle does not clear the hazard; the instruction issues the next cycle.
- ex_valid_o = id_valid && state==RUN && !hz && !serialising. Fire = ex_valid_o && ex_ready_i.
- On fire with writes_rd && rd!=0: cnt[rd]++. On wb_valid_i && wb_rd_i!=0: cnt[wb_rd_i]--. Both on the same register in one cycle: unchanged. An increment at max saturates is illegal: the RTL instead withholds issue (treated as a hazard). A decrement at 0 is ignored, with an assertion.
- FSM:
  RUN: serialising op valid -> DRAIN; hazard -> HAZ.
  HAZ: stall_o=1; hz clears -> RUN.
  DRAIN: stall_o=1; all counters 0 && ex_idle_i -> ISSUE_SER.
  ISSUE_SER: ex_valid_o=1 for the serialising op; fire -> POST.
  POST: wait ex_idle_i -> RUN. This blocks younger instructions behind a CSR/FENCE.
- INVALID op: issued normally (EX raises the trap); not serialising.
- flush_i: takes priority over everything. Next cycle id_valid=0, FSM=RUN, ex_valid_o=0. The scoreboard is not cleared; EX guarantees killed instructions produce no wb. A flush and an IF accept in the same cycle: the accepted instruction is dropped.
- Reset asserted mid-operation: immediate return to reset values regardless of state.
- ex_valid_o stays asserted with stable ex_pc_o until ex_ready_i (no retraction), except on flush_i.

Decomposition:
- kamus_pkg additions: id_state_e {RUN, HAZ, DRAIN, ISSUE_SER, POST}; function is_serialising(operation_e); NOP_INSTR constant.
- Sub-module kamus_scoreboard: NUM_REGS x PEND_W counters with set/clear/query ports (rs1, rs2, rd-saturated) and an all_zero output.

Test Plan:
- Back-to-back independent ADDs, ex_ready_i=1 -> one issue per cycle, stall_o=0, ex_pc_o steps by 4.
- LW x5 issued, then ADD x6,x5,x1; wb x5 after 3 cycles -> ADD held 3 cycles in HAZ and issues the cycle after wb.
- CSRRW with two outstanding loads -> DRAIN until both wb and ex_idle_i; CSR issues alone; next instruction issues only after ex_idle_i.
- ex_ready_i low for 4 cycles -> ex_valid_o/ex_pc_o stable, if_ready_o=0, no counter change.
- flush_i during HAZ with if_valid_i=1 -> ID empty next cycle, FSM=RUN, counters unchanged, fetched instr dropped.
- Issue of a write to x7 and wb of x7 in the same cycle, cnt[x7]=1 -> cnt stays 1; rst_i pulse in DRAIN -> all outputs at reset values asynchronously.
